codec_init_seq: RTL and testbench
=================================

CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PWRUP_CYC, 60000: cycles from reset release to first table fetch.
- NUM_REGS, 32: table depth, 1..256.
- DEV_ADDR, 7'h1A: I2C 7-bit device address.
- MAX_RETRY, 3: extra attempts per entry after a NACK.
- RETRY_GAP, 1000: idle cycles between attempts.
- DLY_UNIT, 1000: cycles per delay-entry count.

REQ-002 Ports, one per line (name, direction, width, meaning):
- Clk, in, 1: clock.
- Rst_n, in, 1: asynchronous active-low reset.
- Reinit, in, 1: pulse that restarts the full sequence.
- Tbl_Idx, out, 8: table read index.
- Tbl_Data, in, 16: entry {reg[6:0], val[8:0]}; valid 1 cycle after Tbl_Idx changes.
- Wr_Start, out, 1: one-cycle write request.
- Wr_Dev, out, 7: device address, constant DEV_ADDR.
- Wr_Word, out, 16: frame to write.
- Wr_Done, in, 1: one-cycle transaction-complete pulse from the I2C master.
- Wr_Nack, in, 1: NACK flag, sampled only with Wr_Done.
- Init_Done, out, 1: sequence completed, sticky.
- Init_Err, out, 1: sequence aborted, sticky.
- Err_Idx, out, 8: index of the failing entry.

Function
REQ-003 States: PWRUP, FETCH, LOAD, SEND, WAIT, GAP, DELAY, NEXT, DONE, ERROR.
REQ-004 PWRUP:
- Counter runs 0..PWRUP_CYC-1.
- On terminal count go to FETCH with Tbl_Idx=0.
REQ-005 FETCH: 1 cycle (ROM latency), then LOAD.
REQ-006 LOAD: register Tbl_Data into Wr_Word, then decode:
- reg==7'h7F and val==9'h1FF: end marker, go to DONE.
- reg==7'h7F otherwise: delay entry, go to DELAY.
- Any other value: go to SEND.
REQ-007 SEND:
- Assert Wr_Start for exactly 1 cycle, then WAIT.
- Wr_Word stays stable from SEND until Wr_Done.
REQ-008 WAIT: on Wr_Done:
- Wr_Nack=0: go to NEXT.
- Wr_Nack=1 and retry count < MAX_RETRY: increment retry count, go to GAP.
- Otherwise: go to ERROR.
REQ-009 GAP: idle RETRY_GAP cycles, then SEND again with the same Wr_Word.
REQ-010 DELAY:
- Wait val*DLY_UNIT cycles; val==0 gives 1 cycle.
- No I2C traffic; then NEXT.
- Counter width holds 511*DLY_UNIT.
REQ-011 NEXT:
- Clear retry count.
- If Tbl_Idx==NUM_REGS-1 go to DONE; else increment Tbl_Idx and go to FETCH.
- Tbl_Idx never wraps.
REQ-012 DONE: Init_Done=1, hold until Reinit or reset.
REQ-013 ERROR: Init_Err=1, Err_Idx=Tbl_Idx captured on entry, hold until Reinit or reset.
REQ-014 Reinit in any state:
- Next cycle: state FETCH, Tbl_Idx=0, retry and delay counters cleared, Init_Done=0, Init_Err=0.
- PWRUP delay is skipped.
- A Wr_Done arriving after Reinit is ignored unless the state is WAIT.
REQ-015 Reinit while in PWRUP: ignored, the power-up count continues.
REQ-016 Wr_Done outside WAIT: ignored.
REQ-017 Wr_Done in the same cycle as Reinit: Reinit wins.
REQ-018 Exclusivity: Init_Done and Init_Err are never both 1. At most one Wr_Start per Wr_Done.

Reset
REQ-019 While Rst_n=0, values are as follows:
- state=PWRUP; all counters=0.
- Tbl_Idx=0, Wr_Start=0, Wr_Word=0.
- Init_Done=0, Init_Err=0, Err_Idx=0.
REQ-020 Reset mid-transaction: abandons the sequence. An in-flight Wr_Done after reset release is ignored (state is PWRUP).

Structure
REQ-021 Shared package codec_init_pkg contains:
- State enum.
- Entry field widths (REG_W=7, VAL_W=9).
- END_MARK=16'hFFFF.
- DLY_REG=7'h7F.
REQ-022 One sub-module: init_timer, a loadable down-counter with a terminal-count pulse. It is shared by PWRUP, GAP and DELAY. The table ROM and the I2C master are external.

Verification
REQ-023 PWRUP_CYC=100, 3-entry table with no NACKs:
- First Wr_Start occurs 101-102 cycles after reset release.
- Wr_Word values are the 3 entries in order.
- Init_Done=1 after the 3rd Wr_Done.
REQ-024 NACK on entry 1, twice, then ACK, with RETRY_GAP=10:
- 3 Wr_Start pulses carry the same word.
- Successive Wr_Start pulses are at least 10 cycles apart.
- Sequence completes, Init_Err=0.
REQ-025 NACK on entry 2, four times, MAX_RETRY=3:
- Init_Err=1, Err_Idx=2, Init_Done=0.
- No further Wr_Start.
REQ-026 Delay entry 16'hFE05 (reg 7F, val 5) with DLY_UNIT=10:
- 50 cycles (±2 for FETCH/LOAD overhead) pass between the previous Wr_Done and the next Wr_Start.
- That delay entry is never written.
REQ-027 End marker at entry 1 of NUM_REGS=8:
- Exactly one write, then Init_Done=1.
REQ-028 Reinit pulse while in WAIT, followed by a stale Wr_Done:
- Stale Wr_Done does not advance the index.
- Sequence restarts at index 0; Init_Done drops, then reasserts on completion.

Source files
------------

// File: rtl/codec_init_pkg.sv
// codec_init_pkg
//   Shared definitions for the codec register-initialisation sequencer:
//   the sequencer state encoding, the table-entry field layout and the two
//   reserved entry encodings (end marker and delay entry).
package codec_init_pkg;

  // Table entry layout: {reg[REG_W-1:0], val[VAL_W-1:0]}
  localparam int REG_W   = 7;
  localparam int VAL_W   = 9;
  localparam int ENTRY_W = REG_W + VAL_W;

  // A reg field of DLY_REG marks a delay entry; all-ones ends the table.
  localparam logic [ENTRY_W-1:0] END_MARK = 16'hFFFF;
  localparam logic [REG_W-1:0]   DLY_REG  = 7'h7F;

  typedef enum logic [3:0] {
    ST_PWRUP = 4'd0,
    ST_FETCH = 4'd1,
    ST_LOAD  = 4'd2,
    ST_SEND  = 4'd3,
    ST_WAIT  = 4'd4,
    ST_GAP   = 4'd5,
    ST_DELAY = 4'd6,
    ST_NEXT  = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERROR = 4'd9
  } state_t;

  function automatic logic is_end(input logic [ENTRY_W-1:0] entry);
    return entry == END_MARK;
  endfunction

  function automatic logic is_delay(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1:VAL_W] == DLY_REG;
  endfunction

endpackage

// File: rtl/codec_init_seq_timer.sv
// init_timer
//   Loadable down-counter shared by the power-up wait, the retry gap and the
//   delay entries. Loading N (N >= 1) produces a one-cycle Tc pulse in the
//   N-th cycle after the load edge, after which the timer goes idle.
//   Loading 0 leaves the timer idle.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   Load        : load Load_Val and start counting (has priority)
//   Load_Val    : number of cycles to count
//   Clr         : abandon the current count
//   Busy        : a count is in progress
//   Tc          : terminal-count pulse (last counted cycle)
module init_timer #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Load,
  input  logic [W-1:0] Load_Val,
  input  logic         Clr,
  output logic         Busy,
  output logic         Tc
);

  logic [W-1:0] count_q;
  logic         busy_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (Clr) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (Load) begin
      count_q <= Load_Val;
      busy_q  <= (Load_Val != '0);
    end else if (busy_q) begin
      if (count_q == W'(1)) begin
        count_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        count_q <= count_q - W'(1);
      end
    end
  end

  assign Busy = busy_q;
  assign Tc   = busy_q && (count_q == W'(1));

endmodule

// File: rtl/codec_init_seq.sv
// codec_init_seq
//   Walks an external register table after power-up and writes every entry
//   to the codec through an external I2C master. Delay entries (reg 7'h7F)
//   pause the sequence, the all-ones entry ends it, NACKed writes are retried
//   after an idle gap, and an entry that keeps failing aborts the sequence.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   Reinit      : restart the table walk from index 0 (ignored in power-up)
//   Tbl_Idx     : table read index; Tbl_Data is valid one cycle later
//   Tbl_Data    : table entry {reg[6:0], val[8:0]}
//   Wr_Start    : one-cycle write request to the I2C master
//   Wr_Dev      : I2C 7-bit device address (constant)
//   Wr_Word     : frame to write
//   Wr_Done     : one-cycle completion pulse from the I2C master
//   Wr_Nack     : NACK flag, meaningful only together with Wr_Done
//   Init_Done   : table completed (held until Reinit/reset)
//   Init_Err    : sequence aborted (held until Reinit/reset)
//   Err_Idx     : index of the entry that failed
//   Dbg_State   : current sequencer state
//
// Write handshake: Wr_Start is high for exactly one cycle per attempt, with
// Wr_Word already stable; Wr_Word then stays stable until the master answers
// with a single Wr_Done pulse (Wr_Nack qualifies it). No new Wr_Start is
// issued before that Wr_Done, and a Wr_Done seen outside WAIT is ignored.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 60000,
  parameter int unsigned NUM_REGS  = 32,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 1000,
  parameter int unsigned DLY_UNIT  = 1000
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Reinit,
  output logic [7:0]         Tbl_Idx,
  input  logic [ENTRY_W-1:0] Tbl_Data,
  output logic               Wr_Start,
  output logic [6:0]         Wr_Dev,
  output logic [ENTRY_W-1:0] Wr_Word,
  input  logic               Wr_Done,
  input  logic               Wr_Nack,
  output logic               Init_Done,
  output logic               Init_Err,
  output logic [7:0]         Err_Idx,
  output state_t             Dbg_State
);

  // The shared timer must hold the longest of the three waits; the delay
  // entry maximum is val=511.
  localparam int unsigned DLY_MAX = 511 * DLY_UNIT;
  localparam int unsigned T_A     = (DLY_MAX > PWRUP_CYC) ? DLY_MAX : PWRUP_CYC;
  localparam int unsigned T_MAX   = (T_A > RETRY_GAP) ? T_A : RETRY_GAP;
  localparam int          TW      = (T_MAX < 2) ? 2 : $clog2(T_MAX + 1);
  localparam int          RW      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  // The timer is loaded on the first power-up cycle after reset release,
  // which is itself count 0, so it runs PWRUP_CYC-1 further cycles.
  localparam logic [TW-1:0] PWR_LOAD = (PWRUP_CYC > 1) ? TW'(PWRUP_CYC - 1) : TW'(1);
  localparam logic [TW-1:0] GAP_LOAD = (RETRY_GAP > 0) ? TW'(RETRY_GAP) : TW'(1);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

  state_t             state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [ENTRY_W-1:0] word_q, word_d;
  logic [7:0]         err_idx_q, err_idx_d;

  logic               tmr_load, tmr_clr, tmr_busy, tmr_tc;
  logic [TW-1:0]      tmr_val;
  logic [TW-1:0]      dly_cyc;

  init_timer #(
    .W (TW)
  ) u_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Load     (tmr_load),
    .Load_Val (tmr_val),
    .Clr      (tmr_clr),
    .Busy     (tmr_busy),
    .Tc       (tmr_tc)
  );

  // Delay length of the entry currently on Tbl_Data; val==0 still waits one
  // cycle so DELAY always terminates through the timer.
  always_comb begin
    dly_cyc = TW'(Tbl_Data[VAL_W-1:0]) * TW'(DLY_UNIT);
    if (dly_cyc == '0) begin
      dly_cyc = TW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_PWRUP;
      idx_q     <= '0;
      retry_q   <= '0;
      word_q    <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      word_q    <= word_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    word_d    = word_q;
    err_idx_d = err_idx_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_clr   = 1'b0;

    // Reinit overrides everything (including a coincident Wr_Done) except
    // the power-up wait, which always runs to completion.
    if (Reinit && (state_q != ST_PWRUP)) begin
      state_d = ST_FETCH;
      idx_d   = '0;
      retry_d = '0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_PWRUP: begin
          if (tmr_tc) begin
            state_d = ST_FETCH;
            idx_d   = '0;
          end else if (!tmr_busy) begin
            tmr_load = 1'b1;
            tmr_val  = PWR_LOAD;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          word_d = Tbl_Data;
          if (is_end(Tbl_Data)) begin
            state_d = ST_DONE;
          end else if (is_delay(Tbl_Data)) begin
            state_d  = ST_DELAY;
            tmr_load = 1'b1;
            tmr_val  = dly_cyc;
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_SEND: state_d = ST_WAIT;
        ST_WAIT: begin
          if (Wr_Done) begin
            if (!Wr_Nack) begin
              state_d = ST_NEXT;
            end else if (retry_q < RW'(MAX_RETRY)) begin
              retry_d  = retry_q + 1'b1;
              state_d  = ST_GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_LOAD;
            end else begin
              state_d   = ST_ERROR;
              err_idx_d = idx_q;
            end
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            state_d = ST_SEND;
          end
        end
        ST_DELAY: begin
          if (tmr_tc) begin
            state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          retry_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_FETCH;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_PWRUP;
      endcase
    end
  end

  assign Tbl_Idx   = idx_q;
  assign Wr_Start  = (state_q == ST_SEND);
  assign Wr_Dev    = DEV_ADDR;
  assign Wr_Word   = word_q;
  assign Init_Done = (state_q == ST_DONE);
  assign Init_Err  = (state_q == ST_ERROR);
  assign Err_Idx   = err_idx_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// tb_codec_init_seq
//   Directed bench for codec_init_seq: a synchronous table ROM, an I2C
//   master responder with a per-write NACK plan, and a scoreboard holding
//   the words expected on each Wr_Start.
module tb_codec_init_seq;
  import codec_init_pkg::*;

  localparam int unsigned PWRUP_CYC = 100;
  localparam int unsigned NUM_REGS  = 8;
  localparam logic [6:0]  DEV       = 7'h1A;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned RETRY_GAP = 10;
  localparam int unsigned DLY_UNIT  = 10;
  localparam int          RESP_LAT  = 3;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Reinit = 1'b0;
  logic [7:0]  Tbl_Idx;
  logic [15:0] Tbl_Data = '0;
  logic        Wr_Start;
  logic [6:0]  Wr_Dev;
  logic [15:0] Wr_Word;
  logic        Wr_Done = 1'b0;
  logic        Wr_Nack = 1'b0;
  logic        Init_Done;
  logic        Init_Err;
  logic [7:0]  Err_Idx;
  state_t      Dbg_State;

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  codec_init_seq #(
    .PWRUP_CYC (PWRUP_CYC),
    .NUM_REGS  (NUM_REGS),
    .DEV_ADDR  (DEV),
    .MAX_RETRY (MAX_RETRY),
    .RETRY_GAP (RETRY_GAP),
    .DLY_UNIT  (DLY_UNIT)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Reinit    (Reinit),
    .Tbl_Idx   (Tbl_Idx),
    .Tbl_Data  (Tbl_Data),
    .Wr_Start  (Wr_Start),
    .Wr_Dev    (Wr_Dev),
    .Wr_Word   (Wr_Word),
    .Wr_Done   (Wr_Done),
    .Wr_Nack   (Wr_Nack),
    .Init_Done (Init_Done),
    .Init_Err  (Init_Err),
    .Err_Idx   (Err_Idx),
    .Dbg_State (Dbg_State)
  );

  // Table ROM: one cycle of read latency.
  logic [15:0] rom [0:255];
  always @(posedge Clk) Tbl_Data <= rom[Tbl_Idx];

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        nack_q[$];
  int          start_t[$];
  int          done_t[$];
  int          exp_rd = 0;
  int          nack_rd = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- I2C master responder ----------------
  initial begin
    int          lat_cnt;
    logic        pend_nack;
    logic [31:0] exp_w;
    lat_cnt   = 0;
    pend_nack = 1'b0;
    forever begin
      @(negedge Clk);
      Wr_Done = 1'b0;
      Wr_Nack = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          Wr_Done = 1'b1;
          Wr_Nack = pend_nack;
          done_cnt++;
          done_t.push_back(cyc);
        end
      end
      if (Wr_Start === 1'b1) begin
        start_cnt++;
        start_t.push_back(cyc);
        // An out-of-range sentinel makes any unplanned write fail.
        exp_w = 32'h0001_0000;
        if (exp_rd < exp_q.size()) begin
          exp_w = {16'h0, exp_q[exp_rd]};
          exp_rd++;
        end
        check_eq("wr_word", {16'h0, Wr_Word}, exp_w);
        check_eq("wr_dev", {25'h0, Wr_Dev}, {25'h0, DEV});
        pend_nack = 1'b0;
        if (nack_rd < nack_q.size()) begin
          pend_nack = nack_q[nack_rd];
          nack_rd++;
        end
        lat_cnt = RESP_LAT;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_write(input logic [15:0] w, input logic nack);
    exp_q.push_back(w);
    nack_q.push_back(nack);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic pulse_reinit();
    @(negedge Clk);
    Reinit = 1'b1;
    @(negedge Clk);
    Reinit = 1'b0;
    check_eq("reinit_state", Dbg_State, ST_FETCH);
    check_eq("reinit_idx", Tbl_Idx, 8'd0);
    check_eq("reinit_done_low", Init_Done, 1'b0);
    check_eq("reinit_err_low", Init_Err, 1'b0);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (Wr_Start !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (Wr_Start !== 1'b1) check_eq("start_timeout", Wr_Start, 1'b1);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (Init_Done !== 1'b1 && Init_Err !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (Init_Done !== 1'b1 && Init_Err !== 1'b1) check_eq("end_timeout", Init_Done | Init_Err, 1'b1);
  endtask

  task automatic check_drained(input string tag);
    check_eq(tag, exp_rd, exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int s0, d0, t0, lat, gap;

    clear_rom();
    Rst_n = 1'b0;
    repeat (4) @(negedge Clk);

    // Reset values
    check_eq("rst_state", Dbg_State, ST_PWRUP);
    check_eq("rst_idx", Tbl_Idx, 8'd0);
    check_eq("rst_wr_start", Wr_Start, 1'b0);
    check_eq("rst_wr_word", Wr_Word, 16'h0);
    check_eq("rst_done", Init_Done, 1'b0);
    check_eq("rst_err", Init_Err, 1'b0);
    check_eq("rst_err_idx", Err_Idx, 8'd0);
    check_eq("rst_wr_dev", Wr_Dev, DEV);

    // Power-up, three writes, end marker; a Reinit inside PWRUP is ignored.
    rom[0] = 16'h0A17; rom[1] = 16'h1C01; rom[2] = 16'h3E55; rom[3] = 16'hFFFF;
    expect_write(16'h0A17, 1'b0);
    expect_write(16'h1C01, 1'b0);
    expect_write(16'h3E55, 1'b0);
    s0 = start_cnt; d0 = done_cnt;
    Rst_n = 1'b1;
    lat = 0;
    while (Wr_Start !== 1'b1 && lat < 300) begin
      @(negedge Clk);
      lat++;
      if (lat == 50) Reinit = 1'b1;
      if (lat == 51) Reinit = 1'b0;
      if (lat == 53) check_eq("pwrup_ignores_reinit", Dbg_State, ST_PWRUP);
    end
    check_eq("pwrup_latency_101_102", (lat >= 101 && lat <= 102), 1'b1);
    wait_end(2000);
    check_eq("t1_done", Init_Done, 1'b1);
    check_eq("t1_err", Init_Err, 1'b0);
    check_eq("t1_starts", start_cnt - s0, 3);
    check_eq("t1_dones_before_done", done_cnt - d0, 3);
    check_drained("t1_drained");

    // Entry 1 NACKed twice then ACKed.
    clear_rom();
    rom[0] = 16'h0201; rom[1] = 16'h0403; rom[2] = 16'hFFFF;
    expect_write(16'h0201, 1'b0);
    expect_write(16'h0403, 1'b1);
    expect_write(16'h0403, 1'b1);
    expect_write(16'h0403, 1'b0);
    s0 = start_cnt; t0 = start_t.size();
    pulse_reinit();
    wait_end(2000);
    check_eq("t2_done", Init_Done, 1'b1);
    check_eq("t2_err", Init_Err, 1'b0);
    check_eq("t2_starts", start_cnt - s0, 4);
    gap = start_t[t0 + 2] - start_t[t0 + 1];
    check_eq("t2_retry_gap1_ge10", gap >= 10, 1'b1);
    gap = start_t[t0 + 3] - start_t[t0 + 2];
    check_eq("t2_retry_gap2_ge10", gap >= 10, 1'b1);
    check_drained("t2_drained");

    // Entry 2 NACKed on every attempt: 1 + MAX_RETRY writes, then abort.
    clear_rom();
    rom[0] = 16'h0A01; rom[1] = 16'h0A02; rom[2] = 16'h0A03; rom[3] = 16'hFFFF;
    expect_write(16'h0A01, 1'b0);
    expect_write(16'h0A02, 1'b0);
    for (int i = 0; i < 4; i++) expect_write(16'h0A03, 1'b1);
    s0 = start_cnt;
    pulse_reinit();
    wait_end(2000);
    check_eq("t3_err", Init_Err, 1'b1);
    check_eq("t3_err_idx", Err_Idx, 8'd2);
    check_eq("t3_done", Init_Done, 1'b0);
    repeat (60) @(negedge Clk);
    check_eq("t3_starts_frozen", start_cnt - s0, 6);
    check_eq("t3_err_held", Init_Err, 1'b1);
    check_drained("t3_drained");

    // Delay entry 7F/5 with DLY_UNIT=10 between two writes.
    clear_rom();
    rom[0] = 16'h1101; rom[1] = 16'hFE05; rom[2] = 16'h1202; rom[3] = 16'hFFFF;
    expect_write(16'h1101, 1'b0);
    expect_write(16'h1202, 1'b0);
    s0 = start_cnt; t0 = start_t.size(); d0 = done_t.size();
    pulse_reinit();
    wait_end(2000);
    check_eq("t4_done", Init_Done, 1'b1);
    check_eq("t4_starts", start_cnt - s0, 2);
    // Outside the 50 delay cycles the path holds 7 fixed cycles: Wr_Done
    // sampled, NEXT/FETCH/LOAD of the delay entry, NEXT/FETCH/LOAD of the
    // following write.
    gap = start_t[t0 + 1] - done_t[d0];
    check_eq("t4_delay_50pm2", (gap - 7 >= 48 && gap - 7 <= 52), 1'b1);
    check_drained("t4_drained");

    // End marker at entry 1: exactly one write.
    clear_rom();
    rom[0] = 16'h2233; rom[1] = 16'hFFFF;
    for (int i = 2; i < 8; i++) rom[i] = 16'h3344;
    expect_write(16'h2233, 1'b0);
    s0 = start_cnt;
    pulse_reinit();
    wait_end(2000);
    check_eq("t5_done", Init_Done, 1'b1);
    check_eq("t5_starts", start_cnt - s0, 1);
    check_eq("t5_idx", Tbl_Idx, 8'd1);
    check_drained("t5_drained");

    // Full table of NUM_REGS writes: stops at the last index, no wrap.
    clear_rom();
    for (int i = 0; i < 8; i++) begin
      rom[i] = 16'h4000 + 16'(i);
      expect_write(16'h4000 + 16'(i), 1'b0);
    end
    rom[8] = 16'h4808;
    s0 = start_cnt;
    pulse_reinit();
    wait_end(4000);
    check_eq("t6_done", Init_Done, 1'b1);
    check_eq("t6_starts", start_cnt - s0, 8);
    check_eq("t6_idx_last", Tbl_Idx, 8'd7);
    check_drained("t6_drained");

    // Reinit while in WAIT; the abandoned write's Wr_Done arrives in LOAD.
    clear_rom();
    rom[0] = 16'h6101; rom[1] = 16'h6202; rom[2] = 16'hFFFF;
    expect_write(16'h6101, 1'b0);
    expect_write(16'h6101, 1'b0);
    expect_write(16'h6202, 1'b0);
    s0 = start_cnt;
    pulse_reinit();
    wait_start(100);
    pulse_reinit();
    repeat (2) @(negedge Clk);
    check_eq("t7_stale_done_idx", Tbl_Idx, 8'd0);
    check_eq("t7_stale_done_state", Dbg_State, ST_SEND);
    wait_end(2000);
    check_eq("t7_done", Init_Done, 1'b1);
    check_eq("t7_err", Init_Err, 1'b0);
    check_eq("t7_starts", start_cnt - s0, 3);
    check_drained("t7_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
